// File: rtl/sysid_pkg.sv
// sysid_pkg: address map, register count and capability-word layout shared by sysid_regs.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package sysid_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
  localparam logic [2:0] ADDR_CAPS      = 3'd5;

  localparam int CAPS_NREGS_LSB   = 0;
  localparam int CAPS_UPTIME_BIT  = 8;
  localparam int CAPS_VERSION_LSB = 16;

  // Assemble the capability word; unlisted bits stay zero.
  function automatic logic [31:0] caps_word(input logic [15:0] version, input logic uptime_en);
    logic [31:0] w;
    w = '0;
    w[CAPS_NREGS_LSB +: 8]    = 8'(NUM_REGS);
    w[CAPS_UPTIME_BIT]        = uptime_en;
    w[CAPS_VERSION_LSB +: 16] = version;
    return w;
  endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// sysid_regs_if: Avalon-MM control-slave bundle between interconnect and sysid_regs.
// Latency: n/a (wires only); read data arrives one cycle after the read strobe.
// Backpressure: none; there is no waitrequest, every strobe is accepted when presented.
interface sysid_regs_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime.sv
// sysid_uptime: 64-bit free-running uptime counter with synchronous clear and high-word snapshot.
// Latency: outputs are flop outputs; clear/snapshot take effect on the edge they are presented.
// Backpressure: none; clear and snapshot are single-cycle strobes always honoured.
module sysid_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  // Clear beats increment; the shadow captures the high word as it was before this edge.
  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (clr) begin
      cnt_d = '0;
    end
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = cnt_q[63:32];
    end
  end

  // Counter and shadow state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign lo        = cnt_q[31:0];
  assign hi_shadow = shadow_q;

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: system ID / timestamp / scratch / uptime / caps register slave; uptime built with SYSID_UPTIME_EN.
// Latency: read data and readdatavalid one cycle after the read strobe; writes land on the strobe edge.
// Backpressure: none; no waitrequest, back-to-back reads return back-to-back valid data.
module sysid_regs #(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1417934875,
  parameter logic [15:0] VERSION     = 16'h0002,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000,
  parameter int          ADDR_W      = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  sysid_regs_if.slave   bus
);
  import sysid_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [2:0]        word;
  logic              in_map;

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvld_q, rvld_d;
  logic [31:0] rd_val;
  logic [31:0] up_lo, up_hi;

  assign addr   = bus.address;
  assign word   = addr[2:0];
  // Words above the low 3-bit window are reserved when ADDR_W is widened.
  assign in_map = (addr >> 3) == '0;

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_EN = 1'b1;

  logic up_clr, up_snap;
  assign up_clr  = bus.write && in_map && (word == ADDR_UPTIME_LO);
  assign up_snap = bus.read  && in_map && (word == ADDR_UPTIME_LO);

  sysid_uptime u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (up_clr),
    .snap      (up_snap),
    .lo        (up_lo),
    .hi_shadow (up_hi)
  );
`else
  localparam logic UPTIME_EN = 1'b0;

  assign up_lo = '0;
  assign up_hi = '0;
`endif

  localparam logic [31:0] CAPS_VAL = caps_word(VERSION, UPTIME_EN);

  // Read mux over pre-edge state, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_val = '0;
    if (in_map) begin
      case (word)
        ADDR_ID:        rd_val = ID_VALUE;
        ADDR_TIMESTAMP: rd_val = TIMESTAMP;
        ADDR_SCRATCH:   rd_val = scratch_q;
        ADDR_UPTIME_LO: rd_val = up_lo;
        ADDR_UPTIME_HI: rd_val = up_hi;
        ADDR_CAPS:      rd_val = CAPS_VAL;
        default:        rd_val = '0;
      endcase
    end
  end

  // Next-state: scratch byte-lane writes, read data capture, one-cycle valid per read.
  always_comb begin
    scratch_d = scratch_q;
    if (bus.write && in_map && (word == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) begin
          scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
        end
      end
    end
    rdata_d = rdata_q;
    if (bus.read) begin
      rdata_d = rd_val;
    end
    rvld_d = bus.read;
  end

  // Register state; reset drops any read in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_RST;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvld_q;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: self-checking bench for sysid_regs against a behavioural register-map model.
// Latency: expects read data one cycle after each read strobe.
// Backpressure: none exercised; the slave has no waitrequest.
module tb_sysid_regs;

  localparam logic [31:0] ID_V   = 32'hCAFE0001;
  localparam logic [31:0] TS_V   = 32'd1417934875;
  localparam logic [15:0] VER_V  = 16'h0002;
  localparam logic [31:0] SRST_V = 32'h5A5A0FF0;
  localparam int          AW     = 3;
`ifdef SYSID_UPTIME_EN
  localparam logic UP_EN = 1'b1;
`else
  localparam logic UP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sysid_regs_if #(.ADDR_W(AW)) bus ();

  sysid_regs #(
    .ID_VALUE    (ID_V),
    .TIMESTAMP   (TS_V),
    .VERSION     (VER_V),
    .SCRATCH_RST (SRST_V),
    .ADDR_W      (AW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the register map as plain variables.
  logic [31:0] m_scratch;
  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0:       return ID_V;
      1:       return TS_V;
      2:       return m_scratch;
      3:       return UP_EN ? m_cnt[31:0] : 32'h0;
      4:       return UP_EN ? m_shadow : 32'h0;
      5:       return {VER_V, 7'd0, UP_EN, 8'd6};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = SRST_V;
    m_cnt     = 64'h0;
    m_shadow  = 32'h0;
    m_rdata   = 32'h0;
  endtask

  // One bus cycle: drive after the previous sample, advance model at the edge, sample 1ns later.
  task automatic do_cycle(input logic rd, input logic wr, input int a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] exp_d, output logic [31:0] got_d,
                          output logic got_v);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = AW'(a);
    bus.writedata  = wd;
    bus.byteenable = be;
    @(posedge clock);
    if (rd) m_rdata = m_read(a);
    if (rd && a == 3) m_shadow = m_cnt[63:32];
    if (wr && a == 2) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
    end
    if (UP_EN && wr && a == 3) m_cnt = 64'h0;
    else m_cnt = m_cnt + 64'd1;
    #1;
    exp_d = m_rdata;
    got_d = bus.readdata;
    got_v = bus.readdatavalid;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  logic [31:0] e, g;
  logic        v;

  task automatic test_reset();
    bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0; bus.byteenable = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.readdata, 32'h0); end
    checks++; if (bus.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rvld: got %b expected 0", bus.readdatavalid); end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_id_reads();
    int addrs[3] = '{0, 1, 5};
    logic [31:0] lit[3];
    lit[0] = ID_V; lit[1] = TS_V; lit[2] = {VER_V, 7'd0, UP_EN, 8'd6};
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, addrs[i], 32'h0, 4'h0, e, g, v);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL id_rvld[%0d]: got %b expected 1", addrs[i], v); end
      checks++; if (g !== lit[i]) begin errors++; $display("FAIL id_data[%0d]: got %h expected %h", addrs[i], g, lit[i]); end
    end
    do_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, e, g, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL idle_rvld: got %b expected 0", v); end
    checks++; if (g !== e) begin errors++; $display("FAIL idle_hold: got %h expected %h", g, e); end
  endtask

  task automatic test_scratch();
    do_cycle(1'b0, 1'b1, 2, 32'h12345678, 4'b1111, e, g, v);
    do_cycle(1'b0, 1'b1, 2, 32'hAABBCCDD, 4'b0101, e, g, v);
    do_cycle(1'b0, 1'b1, 2, 32'hFFFFFFFF, 4'b0000, e, g, v);
    do_cycle(1'b1, 1'b0, 2, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== 32'h12BB56DD) begin errors++; $display("FAIL scratch_lanes: got %h expected %h", g, 32'h12BB56DD); end
    do_cycle(1'b1, 1'b1, 2, 32'h0F0E0D0C, 4'b1111, e, g, v);
    checks++; if (g !== e || v !== 1'b1) begin errors++; $display("FAIL scratch_rw_old: got %h/%b expected %h/1", g, v, e); end
    do_cycle(1'b1, 1'b0, 2, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== e) begin errors++; $display("FAIL scratch_rw_new: got %h expected %h", g, e); end
  endtask

  task automatic test_uptime();
    do_cycle(1'b0, 1'b1, 3, $urandom, 4'($urandom_range(0, 15)), e, g, v);
    repeat (100) do_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, e, g, v);
    do_cycle(1'b1, 1'b0, 3, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== e) begin errors++; $display("FAIL uptime_lo: got %h expected %h", g, e); end
`ifdef SYSID_UPTIME_EN
    checks++; if (g < 32'd100 || g > 32'd103) begin errors++; $display("FAIL uptime_lo_range: got %0d expected 100..103", g); end
`endif
    do_cycle(1'b1, 1'b0, 4, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== e) begin errors++; $display("FAIL uptime_hi: got %h expected %h", g, e); end
`ifdef SYSID_UPTIME_EN
    force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.u_uptime.cnt_q;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
`endif
    // LO then HI across the 32-bit carry, a repeated HI, then a fresh LO/HI pair.
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b0, (i == 0 || i == 3) ? 3 : 4, 32'h0, 4'h0, e, g, v);
      checks++; if (g !== e) begin errors++; $display("FAIL uptime_carry[%0d]: got %h expected %h", i, g, e); end
    end
    // Same-cycle read and clear of LO returns the pre-clear count.
    do_cycle(1'b1, 1'b1, 3, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== e) begin errors++; $display("FAIL uptime_rd_clr: got %h expected %h", g, e); end
    do_cycle(1'b1, 1'b0, 3, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== e) begin errors++; $display("FAIL uptime_after_clr: got %h expected %h", g, e); end
  endtask

  task automatic test_reserved();
    int wa[5] = '{0, 1, 5, 6, 7};
    int ra[6] = '{6, 7, 0, 1, 5, 2};
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, wa[i], $urandom, 4'hF, e, g, v);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b0, ra[i], 32'h0, 4'h0, e, g, v);
      checks++; if (g !== e) begin errors++; $display("FAIL reserved[%0d]: got %h expected %h", ra[i], g, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b0, i, 32'h0, 4'h0, e, g, v);
      checks++; if (v !== 1'b1 || g !== e) begin errors++; $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, g, v, e); end
    end
  endtask

  task automatic test_random();
    logic rd, wr;
    int a;
    for (int n = 0; n < 400; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 7);
      do_cycle(rd, wr, a, $urandom, 4'($urandom_range(0, 15)), e, g, v);
      checks++; if (v !== rd || g !== e) begin errors++; $display("FAIL rand[%0d] a=%0d: got %h/%b expected %h/%b", n, a, g, v, e, rd); end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1'b0, 1'b1, 2, 32'h0BADF00D, 4'hF, e, g, v);
    do_cycle(1'b1, 1'b0, 2, 32'h0, 4'h0, e, g, v);
    checks++; if (v !== 1'b1 || g !== 32'h0BADF00D) begin errors++; $display("FAIL pre_reset_read: got %h/%b expected 0badf00d/1", g, v); end
    // A read is pending when reset hits mid-cycle.
    bus.read = 1'b1; bus.address = '0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin errors++; $display("FAIL async_reset: got %h/%b expected 0/0", bus.readdata, bus.readdatavalid); end
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    checks++; if (bus.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", bus.readdatavalid); end
    #1 reset_n = 1'b1;
    do_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, e, g, v);
    checks++; if (v !== 1'b0 || g !== 32'h0) begin errors++; $display("FAIL post_reset_idle: got %h/%b expected 0/0", g, v); end
    do_cycle(1'b1, 1'b0, 2, 32'h0, 4'h0, e, g, v);
    checks++; if (g !== SRST_V) begin errors++; $display("FAIL scratch_rst: got %h expected %h", g, SRST_V); end
  endtask

  initial begin
    test_reset();
    test_id_reads();
    test_scratch();
    test_uptime();
    test_reserved();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
